// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel strobe divider, h/v counters, syncs, events.
// Optional macro VTG_LOOKAHEAD_EN adds la_hc/la_vc lookahead position ports.
module video_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int CLK_DIV   = 5,
   parameter int CW        = 10,
   parameter int FCW       = 8,
   parameter int LOOKAHEAD = 2
) (
   input  logic           clk_x5,
   input  logic           reset,
   output logic           pix_stb,
   output logic [CW-1:0]  hc,
   output logic [CW-1:0]  vc,
   output logic           de,
   output logic           hsync,
   output logic           vsync,
   output logic           line_start,
   output logic           frame_start,
   output logic           vblank_start,
   output logic [FCW-1:0] frame_count
`ifdef VTG_LOOKAHEAD_EN
   ,
   output logic [CW-1:0]  la_hc,
   output logic [CW-1:0]  la_vc
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic HSP = (HS_POL != 0);
   localparam logic VSP = (VS_POL != 0);

   // Position one pixel later, wrapping exactly at the line and frame totals
   function automatic logic [2*CW-1:0] f_adv(
      input logic [CW-1:0] h,
      input logic [CW-1:0] v
   );
      logic [CW-1:0] nh;
      logic [CW-1:0] nv;
      nh = h + CW'(1);
      nv = v;
      if (h == H_LAST) begin
         nh = '0;
         nv = (v == V_LAST) ? '0 : v + CW'(1);
      end
      return {nv, nh};
   endfunction

   logic [DW-1:0]  r_div;
   logic [CW-1:0]  r_hc;
   logic [CW-1:0]  r_vc;
   logic           r_stb;
   logic           r_de;
   logic           r_hs;
   logic           r_vs;
   logic           r_ls;
   logic           r_fs;
   logic           r_vbs;
   logic [FCW-1:0] r_fc;

   logic           w_tick;
   logic [CW-1:0]  w_hc_nx;
   logic [CW-1:0]  w_vc_nx;
   logic           w_hact;
   logic           w_vact;
   logic           w_lnst;

   assign w_tick = (r_div == DIV_LAST);
   assign {w_vc_nx, w_hc_nx} = f_adv(r_hc, r_vc);
   assign w_hact = (w_hc_nx >= HS_BEG) && (w_hc_nx < HS_END);
   assign w_vact = (w_vc_nx >= VS_BEG) && (w_vc_nx < VS_END);
   assign w_lnst = (w_hc_nx == '0);

   always_ff @(posedge clk_x5 or posedge reset) begin
      if (reset) begin
         r_div <= DIV_LAST;
         r_hc  <= H_LAST;
         r_vc  <= V_LAST;
         r_stb <= 1'b0;
         r_de  <= 1'b0;
         r_hs  <= ~HSP;
         r_vs  <= ~VSP;
         r_ls  <= 1'b0;
         r_fs  <= 1'b0;
         r_vbs <= 1'b0;
         r_fc  <= '1;
      end else begin
         r_stb <= w_tick;
         r_ls  <= 1'b0;
         r_fs  <= 1'b0;
         r_vbs <= 1'b0;
         if (w_tick) begin
            r_div <= '0;
            r_hc  <= w_hc_nx;
            r_vc  <= w_vc_nx;
            r_de  <= (w_hc_nx < H_ACT) && (w_vc_nx < V_ACT);
            r_hs  <= w_hact ? HSP : ~HSP;
            r_vs  <= w_vact ? VSP : ~VSP;
            r_ls  <= w_lnst;
            r_fs  <= w_lnst && (w_vc_nx == '0);
            r_vbs <= w_lnst && (w_vc_nx == V_ACT);
            if (w_lnst && (w_vc_nx == '0))
               r_fc <= r_fc + FCW'(1);
         end else begin
            r_div <= r_div + DW'(1);
         end
      end
   end

   assign pix_stb      = r_stb;
   assign hc           = r_hc;
   assign vc           = r_vc;
   assign de           = r_de;
   assign hsync        = r_hs;
   assign vsync        = r_vs;
   assign line_start   = r_ls;
   assign frame_start  = r_fs;
   assign vblank_start = r_vbs;
   assign frame_count  = r_fc;

`ifdef VTG_LOOKAHEAD_EN
   logic [CW-1:0] r_la_hc;
   logic [CW-1:0] r_la_vc;
   logic [CW-1:0] w_la_hc_nx;
   logic [CW-1:0] w_la_vc_nx;

   assign {w_la_vc_nx, w_la_hc_nx} = f_adv(r_la_hc, r_la_vc);

   // Reset sits one pixel short so the first strobe lands LOOKAHEAD ahead
   always_ff @(posedge clk_x5 or posedge reset) begin
      if (reset) begin
         r_la_hc <= CW'(LOOKAHEAD - 1);
         r_la_vc <= '0;
      end else if (w_tick) begin
         r_la_hc <= w_la_hc_nx;
         r_la_vc <= w_la_vc_nx;
      end
   end

   assign la_hc = r_la_hc;
   assign la_vc = r_la_vc;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the HDMI/DVI designs. It runs on the fast serializer clock. An internal divider produces a pixel strobe. Per pixel it generates the horizontal/vertical counters, data-enable, polarity-configurable syncs, line/frame/vblank event pulses and a frame counter. It replaces hard-wired 640x480 counter logic and feeds symbol encoders and game/scanline logic.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch pixels
H_SYNC, 96, hsync pulse pixels
H_BP, 48, horizontal back porch pixels
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch lines
V_SYNC, 2, vsync pulse lines
V_BP, 33, vertical back porch lines
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
CLK_DIV, 5, clk_x5 cycles per pixel (>=1)
CW, 10, hc/vc width; must hold H_TOTAL-1 and V_TOTAL-1
FCW, 8, frame counter width
LOOKAHEAD, 2, pixels of lookahead (only used with VTG_LOOKAHEAD_EN)

Ports:
clk_x5  in  1  sole clock
reset  in  1  asynchronous, active-high reset
pix_stb  out  1  high for the first clk_x5 cycle of each pixel
hc  out  CW  horizontal counter; 0 = first active pixel
vc  out  CW  vertical counter; 0 = first active line
de  out  1  hc<H_ACTIVE && vc<V_ACTIVE
hsync  out  1  horizontal sync at HS_POL level when active
vsync  out  1  vertical sync at VS_POL level when active
line_start  out  1  pulse: pix_stb && hc==0
frame_start  out  1  pulse: pix_stb && hc==0 && vc==0
vblank_start  out  1  pulse: pix_stb && hc==0 && vc==V_ACTIVE
frame_count  out  FCW  frames started since reset, minus one
la_hc  out  CW  (VTG_LOOKAHEAD_EN only) hc LOOKAHEAD pixels ahead
la_vc  out  CW  (VTG_LOOKAHEAD_EN only) vc LOOKAHEAD pixels ahead

Behaviour:
- Clock and reset: one clock, clk_x5. Reset is asynchronous and active-high.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Line order is active, FP, sync, BP. Frame order is the same.
- Reset values:
  - div_cnt=CLK_DIV-1, hc=H_TOTAL-1, vc=V_TOTAL-1.
  - de=0, hsync=!HS_POL, vsync=!VS_POL.
  - pix_stb, line_start, frame_start and vblank_start all 0.
  - frame_count=all ones.
- First edge after reset release produces pixel (0,0): pix_stb=1, frame_start=1, line_start=1, de=1, frame_count=0.
- Divider: div_cnt counts 0..CLK_DIV-1. On each edge where div_cnt==CLK_DIV-1:
  - div_cnt goes to 0;
  - the position advances;
  - all outputs load their values for the new position;
  - pix_stb goes to 1.
  On every other edge pix_stb=0, event pulses=0, and all other outputs hold. With CLK_DIV=1, pix_stb is constantly 1 after the first edge.
- Advance rules:
  - hc==H_TOTAL-1 → hc=0, with vc wrapping: vc==V_TOTAL-1 → vc=0, else vc+1.
  - Otherwise hc+1.
  - Wrap is exact: hc never equals H_TOTAL and vc never equals V_TOTAL.
- Syncs:
  - hsync active iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC. vsync changes only at hc==0.
- Alignment: all outputs are registered in one stage and describe the same pixel. Latency from the divider wrap to the outputs is 0 extra cycles.
- frame_count: increments by 1 (mod 2^FCW) on each frame_start, wrapping silently.
- Reset mid-operation: all outputs take their reset values immediately, then the sequence restarts as after the first release.

Optional Feature:
Macro: VTG_LOOKAHEAD_EN
- Defined:
  - la_hc/la_vc ports exist and hold the position LOOKAHEAD pixels after (hc,vc), using the same wrap rules across line and frame boundaries.
  - They are updated on the same edges as hc/vc.
  - Reset value is the position LOOKAHEAD-1 pixels after (0,0).
  - Intended for pipelined renderers with multi-cycle lookups. Requires 1 <= LOOKAHEAD < H_TOTAL.
- Undefined: the ports and their logic are absent, and LOOKAHEAD is ignored.

Test Plan:
1. Defaults, release reset → first edge: pix_stb=1, hc=0, vc=0, de=1, frame_start=1, frame_count=0. Next pix_stb exactly 5 clocks later with hc=1.
2. Line timing → de low for hc 640..799. hsync=0 for hc 656..751 (exactly 96 pixels). hc 799→0 with vc+1 and line_start=1.
3. Frame timing → vblank_start at (0,480). vsync=0 for vc 490..491 only. vc 524→0 with frame_start=1 and frame_count 0→1. After 256 frames, frame_count wraps to 0.
4. Small config (H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1) → pix_stb every clock. Totals are 12x7 = 84 clocks per frame. hsync high at hc 9..10, vsync high at vc 5 only.
5. Assert reset asynchronously at hc=300, vc=100, mid-divider → outputs take reset values without waiting for a clock edge. Restart matches scenario 1.
6. VTG_LOOKAHEAD_EN, LOOKAHEAD=2, defaults:
   - at (798,10): la=(0,11);
   - at (799,524): la=(1,0);
   - after reset release, first pixel (0,0) has la=(2,0).
